// File: rtl/rule_stream_arb_pkg.sv
// Shared types and constants for the rule stream arbiter: beat layout,
// FSM encoding and small arithmetic helpers.
package rule_pkg;

  localparam int unsigned RULE_DW      = 128;
  localparam int unsigned RULE_EMPTY_W = 4;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [RULE_EMPTY_W-1:0] empty;
    logic [RULE_DW-1:0]      data;
  } rule_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/rule_stream_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = W'((32'(ptr_i) + off) % N);
      if (!found_o && req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rule_stream_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC rule streams into one
// registered output stream; orphan beats seen while idle are dropped and counted.
module rule_stream_arb
  import rule_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                in_sop,
  input  logic [NUM_SRC-1:0]                in_eop,
  input  logic [NUM_SRC*RULE_EMPTY_W-1:0]   in_empty,
  input  logic [NUM_SRC-1:0]                in_valid,
  input  logic [NUM_SRC*RULE_DW-1:0]        in_data,
  output logic [NUM_SRC-1:0]                in_ready,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic                              out_valid,
  output logic [RULE_EMPTY_W-1:0]           out_empty,
  output logic [RULE_DW-1:0]                out_data,
  output logic [SRC_W-1:0]                  out_src,
  input  logic                              out_ready,
  output logic [15:0]                       orphan_cnt,
  output logic [31:0]                       pkt_cnt
);

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  rule_beat_t       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [15:0]      orphan_cnt_q, orphan_cnt_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] orphan;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_found;
  rule_beat_t         gbeat;
  logic               g_ready;
  logic               accept;

  assign req     = in_valid & in_sop;
  assign orphan  = in_valid & ~in_sop;
  assign g_ready = !out_valid_q || out_ready;
  assign accept  = (state_q == BUSY) && in_valid[grant_q] && g_ready;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    gbeat.sop   = in_sop[grant_q];
    gbeat.eop   = in_eop[grant_q];
    gbeat.empty = in_empty[grant_q*RULE_EMPTY_W +: RULE_EMPTY_W];
    gbeat.data  = in_data[grant_q*RULE_DW +: RULE_DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && gbeat.eop) begin
          rr_ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // A granted source always carries sop in IDLE, so the orphan mask never overlaps it.
  always_comb begin
    in_ready = '0;
    unique case (state_q)
      IDLE: in_ready = orphan;
      BUSY: in_ready[grant_q] = g_ready;
    endcase
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_d       = gbeat;
      out_valid_d = 1'b1;
      out_src_d   = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    pkt_cnt_d    = pkt_cnt_q + 32'(out_valid_q & out_ready & out_q.eop);
    orphan_cnt_d = (state_q == IDLE) ? sat_add16(orphan_cnt_q, count_ones(8'(orphan)))
                                     : orphan_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
      orphan_cnt_q <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      orphan_cnt_q <= orphan_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign out_sop    = out_q.sop;
  assign out_eop    = out_q.eop;
  assign out_empty  = out_q.empty;
  assign out_data   = out_q.data;
  assign out_valid  = out_valid_q;
  assign out_src    = out_src_q;
  assign orphan_cnt = orphan_cnt_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_rule_stream_arb.sv
// Self-checking bench for rule_stream_arb: input-handshake scoreboard plus
// table-driven grant-order vectors and hand-written corner sequences.
module tb_rule_stream_arb;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_sop, in_eop, in_valid, in_ready;
  logic [N*4-1:0]   in_empty;
  logic [N*128-1:0] in_data;
  logic             out_sop, out_eop, out_valid, out_ready;
  logic [3:0]       out_empty;
  logic [127:0]     out_data;
  logic [1:0]       out_src;
  logic [15:0]      orphan_cnt;
  logic [31:0]      pkt_cnt;

  always #5 clk = ~clk;

  rule_stream_arb #(.NUM_SRC(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_empty   (in_empty),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_valid  (out_valid),
    .out_empty  (out_empty),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .orphan_cnt (orphan_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct {
    bit           sop;
    bit           eop;
    bit           orph;
    logic [3:0]   empty;
    logic [127:0] data;
  } beat_t;

  typedef struct {
    logic [1:0]   src;
    bit           sop;
    bit           eop;
    logic [3:0]   empty;
    logic [127:0] data;
    int           acc;
  } exp_t;

  typedef struct {
    logic [3:0]      mask;
    int              n;
    logic [3:0][1:0] ord;
  } vec_t;

  beat_t  stim[N][16];
  int     len[N], pos[N], start[N];
  bit     en[N];
  exp_t   sb[$];
  int     cyc, tcnt, n_chk, n_fail;
  bit     lat_on, stall_prev;
  logic [8:0]   snap_ctrl;
  logic [127:0] snap_data;
  int           ev_n;
  logic [1:0]   ev_src[64];
  bit           ev_sop[64];
  int           ev_cyc[64];
  vec_t         vt[6];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int s, input bit sop, input bit eop, input bit orph,
                     input logic [3:0] emp, input logic [127:0] d);
    stim[s][len[s]] = '{sop: sop, eop: eop, orph: orph, empty: emp, data: d};
    len[s]++;
  endtask

  task automatic clear_stim();
    for (int s = 0; s < N; s++) begin
      len[s] = 0; pos[s] = 0; start[s] = 0; en[s] = 1'b1;
    end
    tcnt = 0;
    ev_n = 0;
  endtask

  function automatic bit all_done();
    for (int s = 0; s < N; s++) if (pos[s] < len[s]) return 1'b0;
    return (sb.size() == 0) && !out_valid;
  endfunction

  // One clock: drive at posedge+1, sample one time unit before the next posedge.
  task automatic cycle();
    exp_t  e;
    beat_t b;
    for (int s = 0; s < N; s++) begin
      if (en[s] && tcnt >= start[s] && pos[s] < len[s]) begin
        b = stim[s][pos[s]];
        in_valid[s] = 1'b1;
        in_sop[s]   = b.sop;
        in_eop[s]   = b.eop;
        in_empty[s*4 +: 4]    = b.empty;
        in_data[s*128 +: 128] = b.data;
      end else begin
        in_valid[s] = 1'b0;
        in_sop[s]   = 1'b0;
        in_eop[s]   = 1'b0;
      end
    end
    #8;
    if (stall_prev) begin
      chk("hold_ctrl", {out_valid, out_sop, out_eop, out_empty, out_src}, snap_ctrl);
      chk("hold_data", out_data, snap_data);
    end
    stall_prev = out_valid && !out_ready;
    snap_ctrl  = {out_valid, out_sop, out_eop, out_empty, out_src};
    snap_data  = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_unexpected: got beat %0h src %0d, expected no beat", out_data, out_src);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_src", out_src, e.src);
        chk("out_sop", out_sop, e.sop);
        chk("out_eop", out_eop, e.eop);
        if (e.eop) chk("out_empty", out_empty, e.empty);
        if (lat_on) chk("latency", cyc, e.acc + 1);
      end
      if (ev_n < 64) begin
        ev_src[ev_n] = out_src; ev_sop[ev_n] = out_sop; ev_cyc[ev_n] = cyc; ev_n++;
      end
    end
    for (int s = 0; s < N; s++) begin
      if (in_valid[s] && in_ready[s]) begin
        b = stim[s][pos[s]];
        if (!b.orph)
          sb.push_back('{src: 2'(s), sop: b.sop, eop: b.eop, empty: b.empty, data: b.data, acc: cyc});
        pos[s]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    tcnt++;
  endtask

  task automatic run_done(input int budget, input string name);
    int k;
    k = 0;
    while (!all_done() && k < budget) begin
      cycle();
      k++;
    end
    n_chk++;
    if (!all_done()) begin
      n_fail++;
      $display("FAIL timeout_%s: got %0d queued beats, expected drain within %0d cycles", name, sb.size(), budget);
    end
  endtask

  task automatic do_reset();
    for (int s = 0; s < N; s++) en[s] = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    clear_stim();
  endtask

  task automatic setv(input int i, input logic [3:0] m, input int n, input logic [3:0][1:0] o);
    vt[i].mask = m; vt[i].n = n; vt[i].ord = o;
  endtask

  initial begin
    int t0, k;
    logic [1:0] cexp[5];
    rst = 1'b1; in_valid = '0; in_sop = '0; in_eop = '0; in_empty = '0; in_data = '0;
    out_ready = 1'b1; n_chk = 0; n_fail = 0; cyc = 0; lat_on = 1'b1; stall_prev = 1'b0;
    clear_stim();
    // grant-order vectors; rr_ptr carries over from one record to the next
    setv(0, 4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0});
    setv(1, 4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1});
    setv(2, 4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2});
    setv(3, 4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0});
    setv(4, 4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3});
    setv(5, 4'b1101, 3, {2'd0, 2'd0, 2'd3, 2'd2});
    @(posedge clk);
    #1;

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop_eop", {out_sop, out_eop}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_empty_src", {out_empty, out_src}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_counters", {orphan_cnt, pkt_cnt}, 0);

    for (int v = 0; v < 6; v++) begin
      clear_stim();
      for (int s = 0; s < N; s++)
        if (vt[v].mask[s]) add(s, 1, 1, 0, 4'(s), 128'hC0DE_0000 | 128'((v << 8) | s));
      run_done(40, "tbl");
      chk($sformatf("tbl%0d_count", v), ev_n, vt[v].n);
      for (int i = 0; i < vt[v].n; i++)
        chk($sformatf("tbl%0d_grant%0d", v, i), ev_src[i], vt[v].ord[i]);
    end
    chk("tbl_pkt_cnt", pkt_cnt, 14);

    // single source, 3-beat packet
    do_reset();
    add(2, 1, 0, 0, 0, 128'hA1);
    add(2, 0, 0, 0, 0, 128'hA2);
    add(2, 0, 1, 0, 5, 128'hA3);
    t0 = cyc;
    run_done(20, "single");
    chk("single_count", ev_n, 3);
    chk("single_first_cyc", ev_cyc[0], t0 + 2);
    chk("single_throughput", ev_cyc[2] - ev_cyc[0], 2);
    for (int i = 0; i < 3; i++) chk("single_src", ev_src[i], 2);
    chk("single_pkt_cnt", pkt_cnt, 1);

    // contention: src0 has two packets, others one each
    do_reset();
    for (int s = 0; s < N; s++) begin
      add(s, 1, 0, 0, 0, 128'h100 + 128'(s * 16));
      add(s, 0, 1, 0, 4'(s + 1), 128'h101 + 128'(s * 16));
    end
    add(0, 1, 0, 0, 0, 128'h200);
    add(0, 0, 1, 0, 7, 128'h201);
    cexp[0] = 0; cexp[1] = 1; cexp[2] = 2; cexp[3] = 3; cexp[4] = 0;
    run_done(60, "contend");
    chk("contend_count", ev_n, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("contend_src%0d", i), ev_src[i], cexp[i / 2]);
    for (int p = 1; p < 5; p++) chk($sformatf("contend_gap%0d", p), ev_cyc[2 * p] - ev_cyc[2 * p - 2], 3);
    chk("contend_pkt_cnt", pkt_cnt, 5);

    // backpressure mid-packet
    do_reset();
    lat_on = 1'b0;
    for (int i = 0; i < 4; i++) add(1, i == 0, i == 3, 0, 4'(i), 128'hB1 + 128'(i));
    k = 0;
    while (pos[1] < 2 && k < 20) begin cycle(); k++; end
    chk("bp_reach", pos[1], 2);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    run_done(30, "bp");
    chk("bp_count", ev_n, 4);
    chk("bp_pkt_cnt", pkt_cnt, 1);
    lat_on = 1'b1;

    // orphans while idle
    do_reset();
    add(1, 0, 0, 1, 0, 128'hDEAD1);
    add(1, 0, 0, 1, 0, 128'hDEAD2);
    add(3, 1, 0, 0, 0, 128'h31);
    add(3, 0, 1, 0, 2, 128'h32);
    start[3] = 1;
    run_done(30, "orphan");
    chk("orphan_cnt2", orphan_cnt, 2);
    chk("orphan_out_count", ev_n, 2);
    chk("orphan_out_src", {ev_src[0], ev_src[1]}, {2'd3, 2'd3});
    clear_stim();
    add(0, 0, 0, 1, 0, 128'hBAD0);
    add(2, 0, 0, 1, 0, 128'hBAD2);
    run_done(10, "orphan_multi");
    chk("orphan_cnt_multi", orphan_cnt, 4);
    in_valid = '1; in_sop = '0;
    #1;
    chk("flood_in_ready", in_ready, 4'hF);
    repeat (16400) @(posedge clk);
    #1;
    in_valid = '0;
    chk("orphan_saturate", orphan_cnt, 16'hFFFF);
    chk("orphan_pkt_cnt", pkt_cnt, 1);

    // reset in the middle of a 4-beat packet
    do_reset();
    add(1, 1, 1, 0, 3, 128'hC0);
    for (int i = 0; i < 4; i++) add(2, i == 0, i == 3, i >= 2, 4'(i), 128'hD1 + 128'(i));
    k = 0;
    while (pos[2] < 2 && k < 20) begin cycle(); k++; end
    chk("rmid_reach", pos[2], 2);
    en[2] = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_out_ctrl", {out_sop, out_eop, out_empty, out_src}, 0);
    chk("rmid_out_data", out_data, 0);
    chk("rmid_counters", {orphan_cnt, pkt_cnt}, 0);
    chk("rmid_sb_empty", sb.size(), 0);
    en[2] = 1'b1;
    ev_n = 0;
    add(0, 1, 1, 0, 1, 128'hE0);
    add(3, 1, 1, 0, 2, 128'hE3);
    run_done(30, "rmid");
    chk("rmid_orphan_cnt", orphan_cnt, 2);
    chk("rmid_count", ev_n, 2);
    chk("rmid_order", {ev_src[0], ev_src[1]}, {2'd0, 2'd3});
    chk("rmid_pkt_cnt", pkt_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rule_stream_arb.md
# rule_stream_arb

Packet-level round-robin arbiter that shares one 128-bit rule stream between `NUM_SRC` requesters. It sits directly upstream of the 128→512 rule packer that feeds PCIe. It grants one source for an entire packet (sop to eop), forwards its beats through a registered output stage, and tags each beat with the source index. Orphan beats (valid without a preceding sop) are dropped and counted.

## Interface
- `NUM_SRC`, 4 — number of requesting rule streams (2..8).
- `SRC_W`, `$clog2(NUM_SRC)` — width of the source tag; derived, not overridden.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_sop`  in  `NUM_SRC`  per-source start of packet.
- `in_eop`  in  `NUM_SRC`  per-source end of packet.
- `in_empty`  in  `NUM_SRC`×4  per-source empty bytes in the last beat.
- `in_valid`  in  `NUM_SRC`  per-source beat valid.
- `in_data`  in  `NUM_SRC`×128  per-source beat data.
- `in_ready`  out  `NUM_SRC`  per-source beat accepted.
- `out_sop`, `out_eop`, `out_valid`  out  1  merged stream control.
- `out_empty`  out  4  merged empty.
- `out_data`  out  128  merged data.
- `out_src`  out  `SRC_W`  index of the source that owns the beat.
- `out_ready`  in  1  downstream (packer) ready.
- `orphan_cnt`  out  16  saturating count of dropped orphan beats.
- `pkt_cnt`  out  32  wrapping count of packets forwarded (eop beats sent).

## Operation
- FSM with two states: `IDLE` and `BUSY`.
  - **IDLE:** requesters are sources with `in_valid & in_sop`. Pick the first one at or after `rr_ptr`, wrapping modulo `NUM_SRC`. Register it as `grant`, go to `BUSY`. No `in_ready` is asserted in this cycle.
  - **BUSY:** `in_ready[grant] = !out_valid | out_ready`. All other `in_ready` are 0.
  - **Beat accepted:** when `in_valid[grant] & in_ready[grant]`, the beat loads into the output register with `out_valid=1` and `out_src=grant`.
  - **End of packet:** when the accepted beat has eop, set `rr_ptr <= (grant+1) mod NUM_SRC` and return to `IDLE`.
- **Single-beat packets** (sop and eop together) take the same path.
- **Orphan beats in IDLE:** a source with `in_valid & !in_sop` that is not being granted gets `in_ready=1` in IDLE. Its beat is discarded and `orphan_cnt` increments (saturates at 0xFFFF). More than one orphan in a cycle adds the number of orphans. In IDLE, orphan draining and grant selection happen in the same cycle.
- **Stray sop in BUSY:** a sop arriving on the granted source while in BUSY is forwarded unchanged. The arbiter does not check packet framing inside a grant.
- **Output register:**
  - Clears `out_valid` on `out_ready` when no new beat loads.
  - Holds all `out_*` stable while `out_valid & !out_ready`.
- **`pkt_cnt`** increments when `out_valid & out_ready & out_eop`.
- **Reset values:** `out_valid`, `out_sop`, `out_eop` = 0; `out_data`, `out_empty`, `out_src` = 0; `in_ready` = 0; counters = 0; `rr_ptr` = 0; state = `IDLE`.
- **Reset mid-packet:** the partial packet is abandoned. On return to IDLE, the rest of that source's packet arrives as orphans and is dropped.

## Timing
- Accept-to-output latency is 1 cycle: a beat accepted at cycle t is on `out_*` at t+1.
- Arbitration bubble is 1 cycle per packet: the grant is decided in the IDLE cycle, and the first beat is accepted at earliest in the next cycle.
- Sustained throughput within a packet is 1 beat/cycle when `out_ready=1`.
- Back-to-back packets are separated by exactly one idle input cycle. On the output this shows as one `out_valid=0` cycle if `out_ready` stayed high.
- `in_ready` is combinational from state, `grant`, `out_valid` and `out_ready`. There is no combinational path from `in_valid` or `in_data` to `in_ready` in BUSY.
- Grant fairness: a requesting source waits at most `NUM_SRC-1` packets.

## Structure
- The shared package `rule_pkg` holds:
  - the rule beat struct (sop, eop, empty[3:0], data[127:0]);
  - constants `RULE_DW=128` and `RULE_EMPTY_W=4`;
  - the FSM state enum `arb_state_t`.
- One sub-module: `rr_pick`, a combinational round-robin priority picker. Inputs: request vector and `rr_ptr`. Outputs: index and found flag.
- Beat muxing, FSM, output register and counters stay in the top.

## Test plan
- **Single source:** src 2 sends a 3-beat packet (data 0xA1..0xA3, empty 5 on last) with `out_ready=1` → outputs appear at accept+1, `out_src=2`, sop on 0xA1, eop+empty=5 on 0xA3, `pkt_cnt=1`.
- **Contention:** all 4 sources hold 2-beat packets, `rr_ptr=0` → grant order 0,1,2,3,0; one idle cycle between packets; no interleaving of beats inside a packet.
- **Backpressure:** `out_ready` low for 3 cycles mid-packet → `out_*` held constant, `in_ready[grant]=0`, no beat lost or duplicated after release.
- **Orphans:** src 1 drives valid without sop for 2 cycles in IDLE while src 3 requests with sop → src 3 granted, `orphan_cnt=2`, src 1 beats absent from output.
- **Reset mid-packet:** assert `rst` after beat 2 of a 4-beat packet → all outputs 0 next cycle; the remaining 2 beats counted as orphans; next sop packet forwarded normally starting from `rr_ptr=0`.
